// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter.
// Used by dmem_arbiter and dmem_arb_starve_ctr. The build option
// DMEM_ARB_RR_EN is interpreted in dmem_arbiter, not here.
package dmem_arb_pkg;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned MASK_W   = 4;
    localparam int unsigned STARVE_W = 4;

    localparam logic MID_M0 = 1'b0;
    localparam logic MID_M1 = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_LOCK_M0 = 2'd1,
        ARB_LOCK_M1 = 2'd2
    } arb_state_t;

    // The memory port is word addressed; the byte offset is always cleared.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// dmem_arb_starve_ctr: starvation tracker for master 1 in the fixed-priority
// build. It counts consecutive cycles in which m1 requests without a grant.
// The count saturates at its maximum value and clears on a grant or when
// m1 idles. starved_o asks the arbiter to give m1 the next idle-state tie.
// dmem_arbiter instantiates this block only when DMEM_ARB_RR_EN is undefined.
module dmem_arb_starve_ctr
    import dmem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 15
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic m1_req_i,
    input  logic m1_gnt_i,
    output logic starved_o
);

    localparam logic [STARVE_W-1:0] CNT_SAT = '1;

    logic [STARVE_W-1:0] cnt_d;
    logic [STARVE_W-1:0] cnt_q;

    // Next count: clear on grant or idle, otherwise saturating increment.
    always_comb begin
        cnt_d = cnt_q;
        if (!m1_req_i || m1_gnt_i) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign starved_o = (32'(cnt_q) >= STARVE_MAX);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master arbiter for the single data-memory port.
// Master 0 is the core LSU and master 1 is the debug/DMA master. A lock
// handshake keeps split accesses atomic, and a response tag routes each
// read back to the master that issued it.
// Build option DMEM_ARB_RR_EN: when defined, idle-state ties alternate
// between the masters (round robin). When undefined, master 0 has fixed
// priority and master 1 is protected by a starvation counter.
//
//   state       | meaning
//   ------------+------------------------------------------------------
//   ARB_IDLE    | port free; arbitrate between m0 and m1
//   ARB_LOCK_M0 | m0 holds the port between halves of a split access
//   ARB_LOCK_M1 | m1 holds the port between halves of a split access
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 15
) (
    input  logic              clk_i,
    input  logic              reset_i,

    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [MASK_W-1:0] m0_wmask_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    input  logic              m0_lock_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,

    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [MASK_W-1:0] m1_wmask_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    input  logic              m1_lock_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m1_rdata_o,

    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [MASK_W-1:0] mem_wmask_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,

    output logic              lock_o
);

    arb_state_t state_d;
    arb_state_t state_q;
    logic       m1_wins_tie;
    logic       tag_valid_d;
    logic       tag_valid_q;
    logic       tag_id_d;
    logic       tag_id_q;

    // The memory port is word addressed, so the byte-offset bits are never used.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{m0_addr_i[1:0], m1_addr_i[1:0]};

`ifdef DMEM_ARB_RR_EN
    logic last_d;
    logic last_q;

    // A tie goes to the master that did not win the most recent grant.
    assign m1_wins_tie = (last_q == MID_M0);

    // Record the most recent winner on every grant, locked or not.
    always_comb begin
        last_d = last_q;
        if (m0_gnt_o) begin
            last_d = MID_M0;
        end else if (m1_gnt_o) begin
            last_d = MID_M1;
        end
    end

    // Round-robin pointer. After reset it reads as "m1 was last", so m0 wins the first tie.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            last_q <= MID_M1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // m0 has fixed priority unless m1 has been starved long enough.
    dmem_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .m1_req_i  (m1_req_i),
        .m1_gnt_i  (m1_gnt_o),
        .starved_o (m1_wins_tie)
    );
`endif

    // Grant decode and next state. Grants are suppressed while reset is asserted.
    always_comb begin
        m0_gnt_o = 1'b0;
        m1_gnt_o = 1'b0;
        state_d  = state_q;
        if (!reset_i) begin
            case (state_q)
                ARB_IDLE: begin
                    if (m0_req_i && m1_req_i) begin
                        m0_gnt_o = !m1_wins_tie;
                        m1_gnt_o = m1_wins_tie;
                    end else begin
                        m0_gnt_o = m0_req_i;
                        m1_gnt_o = m1_req_i;
                    end
                    if (m0_gnt_o && m0_lock_i) begin
                        state_d = ARB_LOCK_M0;
                    end else if (m1_gnt_o && m1_lock_i) begin
                        state_d = ARB_LOCK_M1;
                    end
                end
                ARB_LOCK_M0: begin
                    m0_gnt_o = m0_req_i;
                    if (m0_gnt_o && !m0_lock_i) begin
                        state_d = ARB_IDLE;
                    end
                end
                ARB_LOCK_M1: begin
                    m1_gnt_o = m1_req_i;
                    if (m1_gnt_o && !m1_lock_i) begin
                        state_d = ARB_IDLE;
                    end
                end
                default: begin
                    state_d = ARB_IDLE;
                end
            endcase
        end
    end

    // Arbiter state register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign lock_o = (state_q != ARB_IDLE);

    // Memory port mux. All outputs are zero when no master is granted; the byte mask is zero on reads.
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_wmask_o = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (m0_gnt_o) begin
            mem_en_o    = 1'b1;
            mem_we_o    = m0_we_i;
            mem_wmask_o = m0_we_i ? m0_wmask_i : '0;
            mem_addr_o  = word_addr(m0_addr_i);
            mem_wdata_o = m0_wdata_i;
        end else if (m1_gnt_o) begin
            mem_en_o    = 1'b1;
            mem_we_o    = m1_we_i;
            mem_wmask_o = m1_we_i ? m1_wmask_i : '0;
            mem_addr_o  = word_addr(m1_addr_i);
            mem_wdata_o = m1_wdata_i;
        end
    end

    // Capture the owner of each granted read so the next-cycle data can be routed back.
    always_comb begin
        tag_valid_d = mem_en_o && !mem_we_o;
        tag_id_d    = m1_gnt_o ? MID_M1 : MID_M0;
    end

    // Response tag. An async clear drops any read still in flight when reset arrives.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            tag_valid_q <= 1'b0;
            tag_id_q    <= MID_M0;
        end else begin
            tag_valid_q <= tag_valid_d;
            tag_id_q    <= tag_id_d;
        end
    end

    assign m0_rvalid_o = tag_valid_q && (tag_id_q == MID_M0);
    assign m1_rvalid_o = tag_valid_q && (tag_id_q == MID_M1);
    assign m0_rdata_o  = m0_rvalid_o ? mem_rdata_i : '0;
    assign m1_rdata_o  = m1_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter for the single data-memory port. Master 0 is the core load/store unit; master 1 is a secondary bus master (debug/DMA). Split misaligned core accesses, which take two memory cycles, are kept atomic through a lock handshake. Each read response is routed back to the master that issued it.

## Interface

**Parameters**
- STARVE_MAX, default 15: consecutive losing cycles for m1 before it is force-granted (fixed-priority mode only).

**Ports** (name, direction, width, meaning)
- clk_i  in  1  single clock.
- reset_i  in  1  asynchronous, active-high reset.
- m0_req_i  in  1  access request.
- m0_we_i  in  1  1 = store, 0 = load.
- m0_wmask_i  in  4  byte write enables.
- m0_addr_i  in  32  word-aligned address; bits [1:0] are ignored.
- m0_wdata_i  in  32  store data.
- m0_lock_i  in  1  hold the port after this access (first half of a split).
- m0_gnt_o  out  1  request accepted this cycle.
- m0_rvalid_o  out  1  read data valid.
- m0_rdata_o  out  32  read data; 0 when m0_rvalid_o is low.
- m1_*: identical port set for master 1.
- mem_en_o  out  1  memory access strobe.
- mem_we_o  out  1  write strobe.
- mem_wmask_o  out  4  byte mask; forced to 0 on reads.
- mem_addr_o  out  32  {addr[31:2],2'b0} of the winning master.
- mem_wdata_o  out  32  store data of the winning master.
- mem_rdata_i  in  32  synchronous memory read data, valid 1 cycle after a read strobe.
- lock_o  out  1  arbiter is in a lock state (debug visibility).

## Operation

**State machine**
- States: ARB_IDLE, ARB_LOCK_M0, ARB_LOCK_M1.
- In ARB_IDLE:
  - A grant with lock_i=1 moves to ARB_LOCK_Mx, where x is the granted master.
  - A grant with lock_i=0 stays in ARB_IDLE.
- In ARB_LOCK_Mx:
  - Only master x can be granted; the other master's gnt is 0 regardless of its req.
  - A grant to x with lock_i=0 returns to ARB_IDLE.
  - A grant to x with lock_i=1 stays locked.
  - If x drops req, the lock is held. There is no timeout.

**Grant and port drive**
- At most one gnt per cycle.
- The granted master's we, wmask, addr and wdata drive the mem port in the same cycle, with mem_en_o=1.
- With no grant, all mem_* outputs are 0.

**Arbitration in ARB_IDLE, fixed priority (default)**
- m0 wins ties.
- A 4-bit saturating counter increments each cycle m1_req_i=1 and m1_gnt_o=0.
- The counter clears on an m1 grant or when m1_req_i=0.
- When the counter is at or above STARVE_MAX, m1 wins the next ARB_IDLE tie.
- The counter does not force a grant while in ARB_LOCK_M0.

**Response routing**
- A registered tag {valid, id} captures each granted read.
- The next cycle, mX_rvalid_o=1 for tag id, with mX_rdata_o = mem_rdata_i.
- Writes produce no rvalid.

**Boundary conditions**
- Single requester: granted every cycle it requests.
- Both requesters, m1 in lock: m0 stalls until m1 issues a non-locked grant.
- Read in cycle N followed by a grant to the other master in N+1: the response in N+1 goes to the cycle-N master, and the new access proceeds independently.

## Timing

- Grant is combinational from req and state: zero-cycle acceptance.
- Read latency: rvalid exactly 1 cycle after the read grant.
- Throughput: one access per cycle, with arbitrary read/write/master interleave.
- A split access occupies 2 consecutive cycles when the master re-requests immediately.
- Reset:
  - All gnt, rvalid and mem_* outputs are 0 while reset_i=1.
  - State returns to ARB_IDLE; counter, RR pointer and tag are cleared.
  - RR pointer reset value: "last = m1".
- Reset asserted between a read grant and its response: the response is dropped, with no rvalid after reset release.

## Configuration

**DMEM_ARB_RR_EN**
- Defined:
  - ARB_IDLE ties go to the master that was not granted last; the 1-bit pointer updates on every grant.
  - The starvation counter and STARVE_MAX are compiled out.
- Undefined: fixed priority with the starvation counter, as described in Operation.
- Lock behaviour is identical in both builds.

## Structure

- Package dmem_arb_pkg holds:
  - arb_state_t enum (ARB_IDLE, ARB_LOCK_M0, ARB_LOCK_M1).
  - Master id constants MID_M0=1'b0, MID_M1=1'b1.
  - Width constants for address, data and mask.
- Sub-module dmem_arb_starve_ctr: saturating counter with STARVE_MAX compare; instantiated only when DMEM_ARB_RR_EN is undefined.
- The top level holds the FSM, grant mux, RR pointer and response tag.

## Test plan

1. m0 read at 0x100 with mem_rdata_i=0xDEADBEEF -> m0_gnt_o same cycle; m0_rvalid_o=1 with m0_rdata_o=0xDEADBEEF the next cycle; m1_rvalid_o=0.
2. m0 locked store to 0x104 (wmask 4'b1000), then unlocked store to 0x108 (wmask 4'b0111), with m1 requesting throughout -> m0 granted both cycles, m1_gnt_o=0 until the cycle after m0's unlocked grant.
3. Fixed priority, STARVE_MAX=3, both requesting continuously -> m1 granted in cycle 4; counter cleared; m0 wins again in cycle 5.
4. DMEM_ARB_RR_EN build, both requesting from reset release -> grants alternate m0, m1, m0, m1.
5. m1 read granted, reset_i pulsed in the next cycle before the response -> no m1_rvalid_o after release; state ARB_IDLE; all mem_* outputs 0.
6. m1 locked read, then m1 drops req for 5 cycles while m0 requests -> m0 never granted and lock_o=1 throughout; m1's unlocked access releases the lock and m0 is granted the next cycle.
